// File: rtl/ram_arbiter_if.sv
// Bundle of both requester ports plus the RAM command/return bus for ram_arbiter.
// slave = arbiter side, master = client/RAM side.
interface ram_arbiter_if #(
    parameter int data_width    = 8,
    parameter int address_width = 8
);
    logic                     a_req;
    logic                     a_we;
    logic [address_width-1:0] a_address;
    logic [data_width-1:0]    a_data_in;
    logic                     a_gnt;
    logic [data_width-1:0]    a_data_out;
    logic                     a_rvalid;

    logic                     b_req;
    logic                     b_we;
    logic [address_width-1:0] b_address;
    logic [data_width-1:0]    b_data_in;
    logic                     b_gnt;
    logic [data_width-1:0]    b_data_out;
    logic                     b_rvalid;

    logic [address_width-1:0] ram_address;
    logic [data_width-1:0]    ram_data_in;
    logic                     ram_write_enable;
    logic [data_width-1:0]    ram_data_out;

    modport slave (
        input  a_req, a_we, a_address, a_data_in,
        input  b_req, b_we, b_address, b_data_in,
        input  ram_data_out,
        output a_gnt, a_data_out, a_rvalid,
        output b_gnt, b_data_out, b_rvalid,
        output ram_address, ram_data_in, ram_write_enable
    );

    modport master (
        output a_req, a_we, a_address, a_data_in,
        output b_req, b_we, b_address, b_data_in,
        output ram_data_out,
        input  a_gnt, a_data_out, a_rvalid,
        input  b_gnt, b_data_out, b_rvalid,
        input  ram_address, ram_data_in, ram_write_enable
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM with one-cycle read latency.
// ROUND_ROBIN_EN: alternate on contention; otherwise port A has fixed priority.
module ram_arbiter #(
    parameter int data_width    = 8,
    parameter int address_width = 8
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    logic                     w_a_gnt;
    logic                     w_b_gnt;
    logic                     w_xfer;
    port_e                    w_win;
    logic                     w_we;
    logic [address_width-1:0] w_addr;
    logic [data_width-1:0]    w_din;

    logic [address_width-1:0] r_ram_address;
    logic [data_width-1:0]    r_ram_data_in;
    logic                     r_ram_we;

    logic [2:1]               r_vld_pipe;
    port_e                    r_port1;
    port_e                    r_port2;

    logic [data_width-1:0]    r_a_data_out;
    logic [data_width-1:0]    r_b_data_out;
    logic                     r_a_rvalid;
    logic                     r_b_rvalid;

`ifdef ROUND_ROBIN_EN
    port_e r_last;

    always_comb begin
        w_a_gnt = bus.a_req & (~bus.b_req | (r_last == PORT_B));
        w_b_gnt = bus.b_req & (~bus.a_req | (r_last == PORT_A));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last <= PORT_B;
        else if (w_xfer)
            r_last <= w_win;
    end
`else
    always_comb begin
        w_a_gnt = bus.a_req;
        w_b_gnt = bus.b_req & ~bus.a_req;
    end
`endif

    always_comb begin
        w_xfer = w_a_gnt | w_b_gnt;
        w_win  = w_b_gnt ? PORT_B : PORT_A;
        w_we   = w_b_gnt ? bus.b_we      : bus.a_we;
        w_addr = w_b_gnt ? bus.b_address : bus.a_address;
        w_din  = w_b_gnt ? bus.b_data_in : bus.a_data_in;
    end

    // Address and write data hold between transfers; only the strobe drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_address <= '0;
            r_ram_data_in <= '0;
            r_ram_we      <= 1'b0;
        end else if (w_xfer) begin
            r_ram_address <= w_addr;
            r_ram_data_in <= w_din;
            r_ram_we      <= w_we;
        end else begin
            r_ram_we      <= 1'b0;
        end
    end

    // Stage 1 tracks the command at the RAM input, stage 2 the RAM output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_port1    <= PORT_A;
            r_port2    <= PORT_A;
        end else begin
            r_vld_pipe[1] <= w_xfer & ~w_we;
            r_port1       <= w_win;
            r_vld_pipe[2] <= r_vld_pipe[1];
            r_port2       <= r_port1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rvalid   <= 1'b0;
            r_b_rvalid   <= 1'b0;
            r_a_data_out <= '0;
            r_b_data_out <= '0;
        end else begin
            r_a_rvalid <= r_vld_pipe[2] & (r_port2 == PORT_A);
            r_b_rvalid <= r_vld_pipe[2] & (r_port2 == PORT_B);
            if (r_vld_pipe[2] && r_port2 == PORT_A)
                r_a_data_out <= bus.ram_data_out;
            if (r_vld_pipe[2] && r_port2 == PORT_B)
                r_b_data_out <= bus.ram_data_out;
        end
    end

    assign bus.a_gnt            = w_a_gnt;
    assign bus.b_gnt            = w_b_gnt;
    assign bus.a_rvalid         = r_a_rvalid;
    assign bus.b_rvalid         = r_b_rvalid;
    assign bus.a_data_out       = r_a_data_out;
    assign bus.b_data_out       = r_b_data_out;
    assign bus.ram_address      = r_ram_address;
    assign bus.ram_data_in      = r_ram_data_in;
    assign bus.ram_write_enable = r_ram_we;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM behind it.
// Contention expectations follow ROUND_ROBIN_EN when it is defined.
module tb_ram_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    ram_arbiter_if #(.data_width(8), .address_width(8)) bus();

    ram_arbiter #(.data_width(8), .address_width(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.ram_write_enable)
            mem[bus.ram_address] <= bus.ram_data_in;
        bus.ram_data_out <= mem[bus.ram_address];
    end

    typedef struct {
        logic       ar, awe;
        logic [7:0] aa, ad;
        logic       br, bwe;
        logic [7:0] ba, bd;
        logic       eag, ebg, ewe;
        logic [7:0] eaddr;
        logic       earv;
        logic [7:0] eadout;
        logic       ebrv;
        logic [7:0] ebdout;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ar, awe, input logic [7:0] aa, ad,
                       input logic br, bwe, input logic [7:0] ba, bd,
                       input logic eag, ebg, ewe, input logic [7:0] eaddr,
                       input logic earv, input logic [7:0] eadout,
                       input logic ebrv, input logic [7:0] ebdout);
        vec_t v;
        v.ar = ar; v.awe = awe; v.aa = aa; v.ad = ad;
        v.br = br; v.bwe = bwe; v.ba = ba; v.bd = bd;
        v.eag = eag; v.ebg = ebg; v.ewe = ewe; v.eaddr = eaddr;
        v.earv = earv; v.eadout = eadout; v.ebrv = ebrv; v.ebdout = ebdout;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ar, awe, input logic [7:0] aa, ad,
                         input logic br, bwe, input logic [7:0] ba, bd);
        bus.a_req = ar; bus.a_we = awe; bus.a_address = aa; bus.a_data_in = ad;
        bus.b_req = br; bus.b_we = bwe; bus.b_address = ba; bus.b_data_in = bd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ram_we"},   {31'd0, bus.ram_write_enable}, 0);
        chk({tag, " ram_addr"}, {24'd0, bus.ram_address}, 0);
        chk({tag, " ram_din"},  {24'd0, bus.ram_data_in}, 0);
        chk({tag, " a_rvalid"}, {31'd0, bus.a_rvalid}, 0);
        chk({tag, " b_rvalid"}, {31'd0, bus.b_rvalid}, 0);
        chk({tag, " a_dout"},   {24'd0, bus.a_data_out}, 0);
        chk({tag, " b_dout"},   {24'd0, bus.b_data_out}, 0);
    endtask

    logic [7:0] exp_ag, exp_bg, exp_arv, exp_brv;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        chk("reset a_gnt", {31'd0, bus.a_gnt}, 0);
        chk("reset b_gnt", {31'd0, bus.b_gnt}, 0);
        rst = 1'b0;

        // Preload addr1=0x11, addr2=0x22 through port A, then reset again
        drive(1, 1, 8'h01, 8'h11, 0, 0, 8'h00, 8'h00); tick();
        drive(1, 1, 8'h02, 8'h22, 0, 0, 8'h00, 8'h00); tick();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00); tick();
        rst = 1'b1;
        #2;
        rst = 1'b0;

        // Contention: both read for 4 cycles, then B alone once, then idle
`ifdef ROUND_ROBIN_EN
        exp_ag  = 8'b0000_0101;
        exp_bg  = 8'b0001_1010;
        exp_arv = 8'b0001_0100;
        exp_brv = 8'b0110_1000;
`else
        exp_ag  = 8'b0000_1111;
        exp_bg  = 8'b0001_0000;
        exp_arv = 8'b0011_1100;
        exp_brv = 8'b0100_0000;
`endif
        for (int c = 0; c < 8; c++) begin
            if (c < 4)       drive(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
            else if (c == 4) drive(0, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
            else             drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
            #1;
            chk($sformatf("cont%0d a_gnt", c), {31'd0, bus.a_gnt}, {31'd0, exp_ag[c]});
            chk($sformatf("cont%0d b_gnt", c), {31'd0, bus.b_gnt}, {31'd0, exp_bg[c]});
            tick();
            chk($sformatf("cont%0d a_rvalid", c), {31'd0, bus.a_rvalid}, {31'd0, exp_arv[c]});
            chk($sformatf("cont%0d b_rvalid", c), {31'd0, bus.b_rvalid}, {31'd0, exp_brv[c]});
            if (exp_arv[c]) chk($sformatf("cont%0d a_dout", c), {24'd0, bus.a_data_out}, 32'h11);
            if (exp_brv[c]) chk($sformatf("cont%0d b_dout", c), {24'd0, bus.b_data_out}, 32'h22);
        end

        // Table: write/read on A, write-then-read across ports, B stream
        add(1,1,8'h10,8'h5A, 0,0,8'h00,8'h00, 1,0,1,8'h10, 0,8'h11, 0,8'h22);
        add(1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h10, 0,8'h11, 0,8'h22);
        add(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h10, 0,8'h11, 0,8'h22);
        add(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h10, 1,8'h5A, 0,8'h22);
        add(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h10, 0,8'h5A, 0,8'h22);
        add(1,1,8'h03,8'h77, 0,0,8'h00,8'h00, 1,0,1,8'h03, 0,8'h5A, 0,8'h22);
        add(0,0,8'h00,8'h00, 1,0,8'h03,8'h00, 0,1,0,8'h03, 0,8'h5A, 0,8'h22);
        add(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h03, 0,8'h5A, 0,8'h22);
        add(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h03, 0,8'h5A, 1,8'h77);
        add(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h03, 0,8'h5A, 0,8'h77);
        for (int i = 0; i < 8; i++)
            add(0,0,8'h00,8'h00, 1,1,8'(i),8'(i), 0,1,1,8'(i), 0,8'h5A, 0,8'h77);
        for (int i = 0; i < 8; i++)
            add(0,0,8'h00,8'h00, 1,0,8'(i),8'h00, 0,1,0,8'(i), 0,8'h5A,
                (i >= 2), (i >= 2) ? 8'(i - 2) : 8'h77);
        add(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h07, 0,8'h5A, 1,8'h06);
        add(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h07, 0,8'h5A, 1,8'h07);
        add(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h07, 0,8'h5A, 0,8'h07);

        foreach (vecs[i]) begin
            drive(vecs[i].ar, vecs[i].awe, vecs[i].aa, vecs[i].ad,
                  vecs[i].br, vecs[i].bwe, vecs[i].ba, vecs[i].bd);
            #1;
            chk($sformatf("v%0d a_gnt", i), {31'd0, bus.a_gnt}, {31'd0, vecs[i].eag});
            chk($sformatf("v%0d b_gnt", i), {31'd0, bus.b_gnt}, {31'd0, vecs[i].ebg});
            tick();
            chk($sformatf("v%0d ram_we", i),   {31'd0, bus.ram_write_enable}, {31'd0, vecs[i].ewe});
            chk($sformatf("v%0d ram_addr", i), {24'd0, bus.ram_address},      {24'd0, vecs[i].eaddr});
            chk($sformatf("v%0d a_rvalid", i), {31'd0, bus.a_rvalid},         {31'd0, vecs[i].earv});
            chk($sformatf("v%0d a_dout", i),   {24'd0, bus.a_data_out},       {24'd0, vecs[i].eadout});
            chk($sformatf("v%0d b_rvalid", i), {31'd0, bus.b_rvalid},         {31'd0, vecs[i].ebrv});
            chk($sformatf("v%0d b_dout", i),   {24'd0, bus.b_data_out},       {24'd0, vecs[i].ebdout});
        end

        // Reset one cycle after an A read transfer: the read must be dropped
        drive(1, 0, 8'h10, 8'hEE, 0, 0, 8'h00, 8'h00);
        tick();
        chk("pre-rst ram_addr", {24'd0, bus.ram_address}, 32'h10);
        chk("pre-rst ram_din",  {24'd0, bus.ram_data_in}, 32'hEE);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        rst = 1'b1;
        #1;
        chk_zero("async-rst");
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("post-rst%0d a_rvalid", c), {31'd0, bus.a_rvalid}, 0);
            chk($sformatf("post-rst%0d b_rvalid", c), {31'd0, bus.b_rvalid}, 0);
        end
        drive(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
        #1;
        chk("post-rst cont a_gnt", {31'd0, bus.a_gnt}, 1);
        chk("post-rst cont b_gnt", {31'd0, bus.b_gnt}, 0);
        tick();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
